// File: rtl/hit_cooldown.sv
// Turns the raw collision level into single hit pulses, then holds the player
// invulnerable (with a blink flag) for a frame-counted cooldown window.
module hit_cooldown #(
    parameter int unsigned DAMAGE_QUAL  = 2,
    parameter int unsigned INV_FRAMES   = 60,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       game_on,
    input  logic       damage_in,
    input  logic       vsync_in,
    output logic       player_hit,
    output logic       invulnerable,
    output logic       blink,
    output logic [3:0] hit_count
);

    localparam logic [3:0] QUAL_LAST  = 4'(DAMAGE_QUAL - 1);
    localparam logic [7:0] FRAME_LAST = 8'(INV_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIT,
        COOLDOWN
    } state_t;

    state_t     state, state_nx;
    logic [3:0] qual_cnt, qual_cnt_nx;
    logic [7:0] frame_cnt, frame_cnt_nx;
    logic [7:0] blink_cnt, blink_cnt_nx;
    logic       vsync_prev;
    logic       frame_tick;
    logic       player_hit_nx, invulnerable_nx, blink_nx;
    logic [3:0] hit_count_nx;

    assign frame_tick = vsync_in & ~vsync_prev;

    always_comb begin
        state_nx        = state;
        qual_cnt_nx     = qual_cnt;
        frame_cnt_nx    = frame_cnt;
        blink_cnt_nx    = blink_cnt;
        player_hit_nx   = 1'b0;
        invulnerable_nx = invulnerable;
        blink_nx        = blink;
        hit_count_nx    = hit_count;

        if (!game_on) begin
            state_nx        = IDLE;
            qual_cnt_nx     = '0;
            frame_cnt_nx    = '0;
            blink_cnt_nx    = '0;
            invulnerable_nx = 1'b0;
            blink_nx        = 1'b0;
            hit_count_nx    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx        = ARMED;
                    qual_cnt_nx     = '0;
                    invulnerable_nx = 1'b0;
                    blink_nx        = 1'b0;
                end
                ARMED: begin
                    invulnerable_nx = 1'b0;
                    blink_nx        = 1'b0;
                    if (damage_in) begin
                        if (qual_cnt == QUAL_LAST) begin
                            state_nx        = HIT;
                            player_hit_nx   = 1'b1;
                            invulnerable_nx = 1'b1;
                            blink_nx        = 1'b1;
                            qual_cnt_nx     = '0;
                            frame_cnt_nx    = '0;
                            blink_cnt_nx    = '0;
                            if (hit_count != 4'hF)
                                hit_count_nx = hit_count + 4'd1;
                        end else begin
                            qual_cnt_nx = qual_cnt + 4'd1;
                        end
                    end else begin
                        qual_cnt_nx = '0;
                    end
                end
                // A frame tick landing in the hit cycle is deliberately dropped.
                HIT: begin
                    state_nx        = COOLDOWN;
                    invulnerable_nx = 1'b1;
                end
                COOLDOWN: begin
                    invulnerable_nx = 1'b1;
                    if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            state_nx        = ARMED;
                            invulnerable_nx = 1'b0;
                            blink_nx        = 1'b0;
                            qual_cnt_nx     = '0;
                            frame_cnt_nx    = '0;
                            blink_cnt_nx    = '0;
                        end else begin
                            frame_cnt_nx = frame_cnt + 8'd1;
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt_nx = '0;
                                blink_nx     = ~blink;
                            end else begin
                                blink_cnt_nx = blink_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            qual_cnt     <= '0;
            frame_cnt    <= '0;
            blink_cnt    <= '0;
            vsync_prev   <= 1'b0;
            player_hit   <= 1'b0;
            invulnerable <= 1'b0;
            blink        <= 1'b0;
            hit_count    <= '0;
        end else begin
            state        <= state_nx;
            qual_cnt     <= qual_cnt_nx;
            frame_cnt    <= frame_cnt_nx;
            blink_cnt    <= blink_cnt_nx;
            vsync_prev   <= vsync_in;
            player_hit   <= player_hit_nx;
            invulnerable <= invulnerable_nx;
            blink        <= blink_nx;
            hit_count    <= hit_count_nx;
        end
    end

endmodule
